// File: rtl/tail_light_sequencer.sv
// Tail-light cluster controller: turn/hazard arbitration, step timebase and lamp sequencing.
// Optional brake override enabled by defining TAILLIGHT_BRAKE_EN.
module tail_light_sequencer #(
   parameter int TICK_DIV   = 25_000_000,
   parameter int SEQ_REPEAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left,
   input  logic       right,
   input  logic       hazard,
   input  logic       brake,
   output logic [5:0] light,
   output logic       busy,
   output logic [1:0] mode,
   output logic       step_tick
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam int REP_W = (SEQ_REPEAT > 1) ? $clog2(SEQ_REPEAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(SEQ_REPEAT - 1);

   typedef enum logic [1:0] {
      M_IDLE   = 2'b00,
      M_LEFT   = 2'b01,
      M_RIGHT  = 2'b10,
      M_HAZARD = 2'b11
   } mode_t;

   mode_t            state, state_next;
   logic [1:0]       step, step_next;
   logic [REP_W-1:0] rep, rep_next;
   logic [CNT_W-1:0] count;
   logic             pend_l, pend_r;
   logic             clr_l, clr_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count     <= '0;
         step_tick <= 1'b0;
      end else if (count == CNT_LAST) begin
         count     <= '0;
         step_tick <= 1'b1;
      end else begin
         count     <= count + 1'b1;
         step_tick <= 1'b0;
      end
   end

   // A new request in the same cycle as its grant re-queues it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_l <= 1'b0;
         pend_r <= 1'b0;
      end else begin
         pend_l <= left  | (pend_l & ~clr_l);
         pend_r <= right | (pend_r & ~clr_r);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= M_IDLE;
         step  <= 2'd0;
         rep   <= '0;
      end else if (step_tick) begin
         state <= state_next;
         step  <= step_next;
         rep   <= rep_next;
      end
   end

   always_comb begin
      state_next = state;
      step_next  = step;
      rep_next   = rep;
      clr_l      = 1'b0;
      clr_r      = 1'b0;
      if (step_tick) begin
         unique case (state)
            M_IDLE: begin
               if (hazard) begin
                  state_next = M_HAZARD;
                  step_next  = 2'd1;
               end else if (pend_l && pend_r) begin
                  state_next = M_HAZARD;
                  step_next  = 2'd1;
                  clr_l      = 1'b1;
                  clr_r      = 1'b1;
               end else if (pend_l) begin
                  state_next = M_LEFT;
                  step_next  = 2'd1;
                  clr_l      = 1'b1;
               end else if (pend_r) begin
                  state_next = M_RIGHT;
                  step_next  = 2'd1;
                  clr_r      = 1'b1;
               end
            end
            M_LEFT, M_RIGHT: begin
               if (hazard) begin
                  state_next = M_HAZARD;
                  step_next  = 2'd1;
                  rep_next   = '0;
               end else if (step == 2'd0) begin
                  if (rep == REP_LAST) begin
                     state_next = M_IDLE;
                     rep_next   = '0;
                  end else begin
                     rep_next  = rep + 1'b1;
                     step_next = 2'd1;
                  end
               end else begin
                  step_next = step + 2'd1;
               end
            end
            M_HAZARD: begin
               if (!hazard) begin
                  state_next = M_IDLE;
                  step_next  = 2'd0;
               end else begin
                  step_next = (step == 2'd1) ? 2'd0 : 2'd1;
               end
            end
            default: state_next = M_IDLE;
         endcase
      end
   end

   always_comb begin
      light = 6'b000000;
      unique case (state)
         M_LEFT: begin
            case (step)
               2'd1:    light = 6'b100000;
               2'd2:    light = 6'b110000;
               2'd3:    light = 6'b111000;
               default: light = 6'b000000;
            endcase
         end
         M_RIGHT: begin
            case (step)
               2'd1:    light = 6'b000001;
               2'd2:    light = 6'b000011;
               2'd3:    light = 6'b000111;
               default: light = 6'b000000;
            endcase
         end
         M_HAZARD: light = (step == 2'd1) ? 6'b111111 : 6'b000000;
         default:  light = 6'b000000;
      endcase
`ifdef TAILLIGHT_BRAKE_EN
      // Brake lights every lamp on a side that is not sweeping; hazard flashing is left alone.
      if (brake) begin
         case (state)
            M_IDLE:  light = 6'b111111;
            M_LEFT:  light[2:0] = 3'b111;
            M_RIGHT: light[5:3] = 3'b111;
            default: ;
         endcase
      end
`endif
   end

`ifndef TAILLIGHT_BRAKE_EN
   logic brake_unused;
   assign brake_unused = brake;
`endif

   assign mode = state;
   assign busy = (state != M_IDLE);

endmodule
